// File: rtl/cover_pkg.sv
// Shared types for the toggle-cover tracker: FSM state encoding and the
// 64-bit report index type.
package cover_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } cover_state_t;

  typedef logic [63:0] cover_idx_t;

  // Bits needed to number n events; never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit priority encoder: idx is the position of the lowest set bit
// of req, any flags that at least one bit is set.
module cover_prio_enc #(
  parameter int N  = 6,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Walk downwards so the lowest set bit is written last and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/toggle_cover_tracker.sv
// Toggle-cover tracker: detects rise/fall events on each bit of sig, pulses
// them on valid, keeps a sticky coverage map and serialises reports.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | waiting for the first sample_en cycle to capture a baseline
// ST_RUN  | sampling sig on sample_en, raising and reporting events
// ST_DONE | everything covered (first-hit mode); reports drain, no sampling
module toggle_cover_tracker
  import cover_pkg::*;
#(
  parameter int         WIDTH          = 3,
  parameter cover_idx_t COVER_INDEX    = 64'd0,
  parameter bit         FIRST_HIT_ONLY = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [WIDTH-1:0]     sig,
  output logic [2*WIDTH-1:0]   valid,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output cover_idx_t           rpt_index,
  output logic [2*WIDTH-1:0]   covered,
  output logic                 all_covered,
  output logic [15:0]          drop_cnt
);

  localparam int NEV = 2 * WIDTH;
  localparam int IW  = idx_width(NEV);

  cover_state_t   state, state_nxt;
  logic           capture, sample_go;
  logic [WIDTH-1:0] prev_sig;
  logic [NEV-1:0] det, emit, clr, pending, pending_nxt, drops;
  logic [IW-1:0]  rpt_bit, enc_idx;
  logic           enc_any, accept, hold;
  logic [16:0]    drop_sum;

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    sample_go = 1'b0;
    case (state)
      ST_INIT: begin
        if (sample_en) begin
          capture   = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        sample_go = sample_en;
        if (FIRST_HIT_ONLY && all_covered) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    det = '0;
    for (int i = 0; i < WIDTH; i++) begin
      det[2*i]   = sig[i] & ~prev_sig[i];
      det[2*i+1] = ~sig[i] & prev_sig[i];
    end
  end

  assign emit        = sample_go ? (det & (FIRST_HIT_ONLY ? ~covered : {NEV{1'b1}})) : '0;
  assign accept      = rpt_valid && rpt_ready;
  assign hold        = rpt_valid && !rpt_ready;
  assign clr         = accept ? (NEV'(1) << rpt_bit) : '0;
  // A re-detection in the accept cycle re-arms the bit and is not a drop.
  assign pending_nxt = (pending & ~clr) | emit;
  assign drops       = emit & pending & ~clr;
  assign all_covered = &covered;

  always_comb begin
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < NEV; i++) begin
      drop_sum = drop_sum + 17'(drops[i]);
    end
  end

  cover_prio_enc #(
    .N  (NEV),
    .IW (IW)
  ) u_prio (
    .req (pending_nxt),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_sig  <= '0;
      valid     <= '0;
      covered   <= '0;
      pending   <= '0;
      drop_cnt  <= '0;
      rpt_valid <= 1'b0;
      rpt_bit   <= '0;
      rpt_index <= '0;
    end else begin
      if (capture || sample_go) prev_sig <= sig;
      valid    <= emit;
      covered  <= covered | emit;
      pending  <= pending_nxt;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      // The presented report stays frozen until the consumer takes it.
      if (!hold) begin
        rpt_valid <= enc_any;
        rpt_bit   <= enc_idx;
        rpt_index <= COVER_INDEX + cover_idx_t'(enc_idx);
      end
    end
  end

endmodule
